wb_spram_slave: RTL and testbench

- Wishbone B3 slave front-end sitting directly upstream of the single-port byte-write SRAM wrapper.
- Converts classic and registered-feedback burst cycles into SRAM address, chip-enable, byte-write and data strobes.
- Absorbs the SRAM's one-cycle registered read latency, so bursts sustain one beat per cycle after a single initial wait state.
- Flags accesses outside the memory window with err.

---
 rtl/wb_spram_slave.sv | 110 +++++++++++
 tb/tb_wb_spram_slave.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_spram_slave.sv
// wb_spram_slave: Wishbone B3 classic/burst slave driving a single-port byte-write SRAM
// with one-cycle registered reads; reads are prefetched so bursts run at one beat per cycle.
module wb_spram_slave #(
    parameter int          dw             = 32,
    parameter int          aw             = 32,
    parameter int          col_w          = 8,
    parameter int          nb_w           = dw / col_w,
    parameter int          nb_lg          = 2,
    parameter logic [31:0] mem_size_bytes = 32'h0000_0400
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [aw-1:0]   wb_adr_i,
    input  logic [dw-1:0]   wb_dat_i,
    input  logic [nb_w-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic [2:0]      wb_cti_i,
    input  logic [1:0]      wb_bte_i,
    output logic [dw-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic [aw-1:0]   sram_adr_o,
    output logic            sram_ce_o,
    output logic [nb_w-1:0] sram_we_o,
    output logic [dw-1:0]   sram_dat_o,
    input  logic [dw-1:0]   sram_dat_i
);
    localparam logic [aw-1:0] mem_bytes = aw'(mem_size_bytes);
    localparam logic [aw-1:0] mem_words = aw'(mem_size_bytes / 32'(nb_w));

    typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

    state_t          state_q, state_d;
    logic [aw-1:0]   adr_q, adr_d, widx, nxt, wrap_m, adr_inc;
    logic            req, oor, last, ack, err, ce;
    logic [nb_w-1:0] we;
    logic [aw-1:0]   sram_adr;

    assign req     = wb_cyc_i & wb_stb_i;
    assign widx    = wb_adr_i >> nb_lg;
    assign oor     = wb_adr_i >= mem_bytes;
    assign last    = !(wb_cti_i == 3'b001 || wb_cti_i == 3'b010);
    assign adr_inc = adr_q + aw'(1);
    assign wrap_m  = wb_bte_i == 2'b01 ? aw'(3) : wb_bte_i == 2'b10 ? aw'(7) : aw'(15);
    // Wrapping bursts only advance the low bits; linear bursts wrap at the end of memory.
    assign nxt = wb_cti_i == 3'b001 ? adr_q :
                 wb_bte_i == 2'b00  ? (adr_q == mem_words - aw'(1) ? '0 : adr_inc) :
                 (adr_q & ~wrap_m) | (adr_inc & wrap_m);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        ack      = 1'b0;
        err      = 1'b0;
        ce       = 1'b0;
        we       = '0;
        sram_adr = widx;
        case (state_q)
            IDLE: begin
                ce = req & ~wb_we_i & ~oor;
                if (req) begin
                    state_d = oor ? ERR : ACTIVE;
                    adr_d   = oor ? adr_q : widx;
                end
            end
            ACTIVE: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    ack      = wb_stb_i;
                    ce       = 1'b1;
                    sram_adr = adr_q;
                    we       = ack & wb_we_i ? wb_sel_i : '0;
                    // Prefetch the next read word so the following beat needs no wait state.
                    if (ack && last) begin
                        state_d = IDLE;
                    end else if (ack) begin
                        adr_d    = nxt;
                        sram_adr = wb_we_i ? adr_q : nxt;
                    end
                end
            end
            ERR: begin
                err     = req;
                state_d = req || !wb_cyc_i ? IDLE : ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wb_ack_o   = ack & ~rst_i;
    assign wb_err_o   = err & ~rst_i;
    assign sram_we_o  = rst_i ? '0 : we;
    assign sram_ce_o  = ce & ~rst_i;
    assign sram_adr_o = sram_adr;
    assign sram_dat_o = wb_dat_i;
    assign wb_dat_o   = sram_dat_i;
endmodule

// File: tb/tb_wb_spram_slave.sv
// tb_wb_spram_slave: directed bench for wb_spram_slave with an SRAM model and a read-data scoreboard.
module tb_wb_spram_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, dat, rdat, sram_adr, sram_wdat, rd_q;
    logic [3:0]  sel, sram_we;
    logic        we, cyc, stb, ack, err, sram_ce;
    logic [2:0]  cti;
    logic [1:0]  bte;

    logic [31:0] mem     [0:255];
    logic [31:0] exp_mem [0:255];
    logic [31:0] exp_q   [$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    wb_spram_slave dut (
        .clk_i(clk), .rst_i(rst),
        .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_we_i(we),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(rdat), .wb_ack_o(ack), .wb_err_o(err),
        .sram_adr_o(sram_adr), .sram_ce_o(sram_ce), .sram_we_o(sram_we),
        .sram_dat_o(sram_wdat), .sram_dat_i(rd_q)
    );

    // Single-port byte-write SRAM, read-first, one-cycle registered read.
    always @(posedge clk) begin
        if (sram_ce) begin
            for (int b = 0; b < 4; b++)
                if (sram_we[b]) mem[sram_adr[7:0]][8*b +: 8] <= sram_wdat[8*b +: 8];
            rd_q <= mem[sram_adr[7:0]];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        else chk(tag, rdat, exp_q.pop_front());
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drop;
        cyc = 0; stb = 0; we = 0; cti = 0; bte = 0; sel = 0;
    endtask

    task automatic idle;
        tick;
        drop;
    endtask

    task automatic classic(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        tick;
        adr = a; we = w; dat = d; sel = s; cyc = 1; stb = 1; cti = 0; bte = 0;
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) exp_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
        end else exp_q.push_back(exp_mem[a[9:2]]);
        @(negedge clk);
        chk("cl_wait_ack", 32'(ack), 0);
        chk("cl_wait_we", 32'(sram_we), 0);
        tick;
        @(negedge clk);
        chk("cl_ack", 32'(ack), 1);
        chk("cl_adr", sram_adr, a >> 2);
        chk("cl_we", 32'(sram_we), w ? 32'(s) : 0);
        chk("cl_ce", 32'(sram_ce), 1);
        if (!w) pop_chk("cl_rdata");
    endtask

    function automatic logic [7:0] bword(input logic [7:0] w0, input logic [1:0] b, input int i);
        logic [7:0] lin;
        lin = w0 + 8'(i);
        return b == 2'b01 ? {w0[7:2], lin[1:0]} : lin;
    endfunction

    task automatic burst(input logic [7:0] w0, input logic [1:0] b, input int n, input bit gap);
        logic [31:0] held;
        for (int i = 0; i < n; i++) exp_q.push_back(exp_mem[bword(w0, b, i)]);
        tick;
        adr = {22'b0, w0, 2'b00}; we = 0; sel = 4'hF; cyc = 1; stb = 1; cti = 3'b010; bte = b;
        @(negedge clk);
        chk("bu_wait_ack", 32'(ack), 0);
        for (int i = 0; i < n; i++) begin
            tick;
            stb = 1;
            cti = i == n - 1 ? 3'b111 : 3'b010;
            @(negedge clk);
            chk("bu_ack", 32'(ack), 1);
            pop_chk("bu_rdata");
            if (gap && i == 0) begin
                tick;
                stb = 0;
                @(negedge clk);
                chk("gap_ack0", 32'(ack), 0);
                chk("gap_adr0", sram_adr, 32'(bword(w0, b, 1)));
                held = sram_adr;
                tick;
                @(negedge clk);
                chk("gap_ack1", 32'(ack), 0);
                chk("gap_adr_stable", sram_adr, held);
            end
        end
        tick;
        drop;
        @(negedge clk);
        chk("bu_done_ack", 32'(ack), 0);
    endtask

    initial begin
        rst = 1; drop; adr = 0; dat = 0;
        #12;
        chk("rst_ack", 32'(ack), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_we", 32'(sram_we), 0);
        @(negedge clk);
        rst = 0;

        classic(32'h10, 1, 32'hDEADBEEF, 4'hF);
        classic(32'h10, 0, 0, 0);
        chk("rd_deadbeef", rdat, 32'hDEADBEEF);
        idle;
        classic(32'h10, 1, 32'h0000_5A00, 4'b0010);
        classic(32'h10, 0, 0, 0);
        chk("rd_bytewr", rdat, 32'hDEAD5AEF);
        classic(32'h10, 1, 32'hFFFF_FFFF, 4'b0000);
        classic(32'h10, 0, 0, 0);
        idle;

        for (int i = 4; i <= 12; i++)
            classic(32'(i) << 2, 1, (i >= 8 && i <= 11) ? 32'(i - 7) : 32'h100 + 32'(i), 4'hF);
        classic(32'h3FC, 1, 32'hAAAA_0255, 4'hF);
        classic(32'h000, 1, 32'hAAAA_0000, 4'hF);
        idle;

        burst(8'd8, 2'b00, 4, 0);
        burst(8'd6, 2'b01, 4, 0);
        burst(8'd8, 2'b00, 4, 1);
        burst(8'd255, 2'b00, 2, 0);

        tick;
        adr = 32'h400; we = 0; cyc = 1; stb = 1; cti = 0;
        @(negedge clk);
        chk("oor_idle_ce", 32'(sram_ce), 0);
        chk("oor_idle_err", 32'(err), 0);
        tick;
        @(negedge clk);
        chk("oor_err", 32'(err), 1);
        chk("oor_ack", 32'(ack), 0);
        chk("oor_ce", 32'(sram_ce), 0);
        chk("oor_we", 32'(sram_we), 0);
        idle;
        @(negedge clk);
        chk("oor_err_clear", 32'(err), 0);

        tick;
        adr = 32'h30; we = 1; dat = 32'hBAD0_BAD0; sel = 4'hF; cyc = 1; stb = 1; cti = 3'b010; bte = 0;
        @(negedge clk);
        chk("wb_wait_ack", 32'(ack), 0);
        tick;
        @(negedge clk);
        chk("wb_ack", 32'(ack), 1);
        chk("wb_we", 32'(sram_we), 4'hF);
        #2 rst = 1;
        #1;
        chk("mrst_ack", 32'(ack), 0);
        chk("mrst_we", 32'(sram_we), 0);
        tick;
        @(negedge clk);
        chk("mrst_hold_ack", 32'(ack), 0);
        drop;
        rst = 0;
        tick;
        @(negedge clk);
        chk("post_rst_ack", 32'(ack), 0);
        classic(32'h30, 0, 0, 0);
        idle;

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
